// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - stall/flush sequencer for the fetch/read/execute core
// Performance counters are built only when PIPE_CTRL_PERF_EN is defined.

module pipeline_controller #(
  parameter int GPR_SIZE     = 3,
  parameter int STALL_CYCLES = 2,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rd_valid,
  input  logic                   rd_use0,
  input  logic                   rd_use1,
  input  logic [GPR_SIZE-1:0]    rd_src0,
  input  logic [GPR_SIZE-1:0]    rd_src1,
  input  logic                   ex_wr_en,
  input  logic [GPR_SIZE-1:0]    ex_dest,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  input  logic                   branch_taken,
  input  logic                   halt_instr,
  output logic                   halt_front,
  output logic                   halt_back,
  output logic                   bubble,
  output logic                   flush,
  output logic                   cpu_halted,
  output logic [COUNT_WIDTH-1:0] stall_count,
  output logic [COUNT_WIDTH-1:0] flush_count
);

  typedef enum logic [2:0] {RUN, DATA_STALL, MEM_WAIT, FLUSH, HALTED} state_t;

  localparam logic [2:0] STALL_INIT = 3'(STALL_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] stall_left_q, stall_left_d;

  logic hazard, mem_wait, halted;
  logic run_hazard, in_stall, mem_hold, susp_hold, branch_flush;

  assign hazard = rd_valid & ex_wr_en &
                  ((rd_use0 & (rd_src0 == ex_dest)) | (rd_use1 & (rd_src1 == ex_dest)));
  assign mem_wait = mem_req & ~mem_ready;
  assign halted   = (state_q == HALTED);

  // stall_left counts remaining DATA_STALL cycles; nonzero in MEM_WAIT means a stall is suspended
  assign run_hazard   = (state_q == RUN) & hazard;
  assign in_stall     = (state_q == DATA_STALL);
  assign mem_hold     = (state_q == MEM_WAIT) & ~mem_ready;
  assign susp_hold    = (state_q == MEM_WAIT) & mem_ready & (stall_left_q != 3'd0);
  assign branch_flush = ~halted & branch_taken & ~halt_instr & ~mem_wait;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      stall_left_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      stall_left_q <= stall_left_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stall_left_d = stall_left_q;
    halt_back    = halted | mem_wait | mem_hold | halt_instr;
    halt_front   = halt_back | run_hazard | in_stall | susp_hold;
    bubble       = (run_hazard | in_stall | susp_hold) & ~halt_back;
    flush        = branch_flush | (state_q == FLUSH);
    cpu_halted   = halted;

    if (!halted) begin
      if (halt_instr) begin
        state_d      = HALTED;
        stall_left_d = 3'd0;
      end else if (mem_wait) begin
        state_d = MEM_WAIT;
        // the detecting stall cycle still counts before the stall is parked
        if (in_stall) stall_left_d = stall_left_q - 3'd1;
      end else if (branch_taken) begin
        state_d      = FLUSH;
        stall_left_d = 3'd0;
      end else begin
        case (state_q)
          RUN: begin
            if (hazard && STALL_CYCLES > 1) begin
              state_d      = DATA_STALL;
              stall_left_d = STALL_INIT;
            end
          end
          DATA_STALL: begin
            stall_left_d = stall_left_q - 3'd1;
            if (stall_left_q == 3'd1) state_d = RUN;
          end
          MEM_WAIT: begin
            if (mem_ready) state_d = (stall_left_q != 3'd0) ? DATA_STALL : RUN;
          end
          default: state_d = RUN;
        endcase
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [COUNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic [COUNT_WIDTH-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (!halted) begin
      if (halt_front && stall_count_q != '1) stall_count_d = stall_count_q + COUNT_WIDTH'(1);
      if (branch_flush && flush_count_q != '1) flush_count_d = flush_count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - scoreboard bench for pipeline_controller
// Reference model tracks owed stall cycles, parked memory waits and pending flushes.

module tb_pipeline_controller;

  localparam int SC   = 3;
  localparam int CW   = 16;
  localparam int MAXC = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rd_valid, rd_use0, rd_use1, ex_wr_en;
  logic [2:0]    rd_src0, rd_src1, ex_dest;
  logic          mem_req, mem_ready, branch_taken, halt_instr;
  logic          halt_front, halt_back, bubble, flush, cpu_halted;
  logic [CW-1:0] stall_count, flush_count;

  always #5 clock = ~clock;

  pipeline_controller #(.GPR_SIZE(3), .STALL_CYCLES(SC), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .rd_valid(rd_valid), .rd_use0(rd_use0), .rd_use1(rd_use1),
    .rd_src0(rd_src0), .rd_src1(rd_src1),
    .ex_wr_en(ex_wr_en), .ex_dest(ex_dest),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .halt_instr(halt_instr),
    .halt_front(halt_front), .halt_back(halt_back), .bubble(bubble),
    .flush(flush), .cpu_halted(cpu_halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  typedef struct packed {
    logic          hf, hb, bub, fl, ch;
    logic [CW-1:0] sc, fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hf_seen  = 0;
  int   fl_seen  = 0;

  bit m_halted, m_flush_next, m_in_mem;
  int m_owed, m_sc, m_fc;
  bit n_halted, n_flush_next, n_in_mem;
  int n_owed, n_sc, n_fc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_halted = 0; m_flush_next = 0; m_in_mem = 0; m_owed = 0; m_sc = 0; m_fc = 0;
  endtask

  // Outputs for the current inputs, plus the model state after the next edge
  task automatic model_cycle(output exp_t e);
    bit hz, mw, bf, stalling, run, hold_mem, hold_susp;
    hz = rd_valid && ex_wr_en && ((rd_use0 && rd_src0 == ex_dest) || (rd_use1 && rd_src1 == ex_dest));
    mw = mem_req && !mem_ready;
    e = '0;
    n_halted = m_halted; n_flush_next = m_flush_next; n_in_mem = m_in_mem;
    n_owed = m_owed; n_sc = m_sc; n_fc = m_fc;
    if (m_halted) begin
      e.hf = 1; e.hb = 1; e.ch = 1;
    end else begin
      stalling  = !m_in_mem && m_owed > 0;
      run       = !m_in_mem && m_owed == 0 && !m_flush_next;
      hold_mem  = m_in_mem && !mem_ready;
      hold_susp = m_in_mem && mem_ready && m_owed > 0;
      bf        = branch_taken && !halt_instr && !mw;
      e.hb  = mw || hold_mem || halt_instr;
      e.hf  = e.hb || (run && hz) || stalling || hold_susp;
      e.bub = ((run && hz) || stalling || hold_susp) && !e.hb;
      e.fl  = bf || m_flush_next;
      if (e.hf && m_sc < MAXC) n_sc = m_sc + 1;
      if (bf && m_fc < MAXC) n_fc = m_fc + 1;
      if (halt_instr) n_halted = 1;
      else if (mw) begin
        n_in_mem = 1; n_flush_next = 0;
        if (stalling) n_owed = m_owed - 1;
      end else if (branch_taken) begin
        n_flush_next = 1; n_owed = 0; n_in_mem = 0;
      end else begin
        n_flush_next = 0;
        if (m_in_mem) begin
          if (mem_ready) n_in_mem = 0;
        end else if (stalling) n_owed = m_owed - 1;
        else if (run && hz) n_owed = SC - 1;
      end
    end
`ifdef PIPE_CTRL_PERF_EN
    e.sc = CW'(m_sc);
    e.fc = CW'(m_fc);
`endif
  endtask

  task automatic model_commit();
    m_halted = n_halted; m_flush_next = n_flush_next; m_in_mem = n_in_mem;
    m_owed = n_owed; m_sc = n_sc; m_fc = n_fc;
  endtask

  task automatic step();
    exp_t e;
    model_cycle(e);
    exp_q.push_back(e);
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic drive(input bit hz, input bit mreq, input bit mrdy, input bit br, input bit hlt);
    rd_valid = hz; rd_use0 = hz; rd_use1 = 1'b0; rd_src0 = 3'd3; rd_src1 = 3'd5;
    ex_wr_en = hz; ex_dest = hz ? 3'd3 : 3'd6;
    mem_req = mreq; mem_ready = mrdy; branch_taken = br; halt_instr = hlt;
    step();
  endtask

  task automatic do_reset();
    rd_valid = 0; rd_use0 = 0; rd_use1 = 0; rd_src0 = 0; rd_src1 = 0;
    ex_wr_en = 0; ex_dest = 0; mem_req = 0; mem_ready = 0; branch_taken = 0; halt_instr = 0;
    reset = 1'b0;
    #1;
    chk("reset_halt_front", halt_front, 0);
    chk("reset_halt_back", halt_back, 0);
    chk("reset_bubble", bubble, 0);
    chk("reset_flush", flush, 0);
    chk("reset_cpu_halted", cpu_halted, 0);
    chk("reset_stall_count", stall_count, 0);
    chk("reset_flush_count", flush_count, 0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    exp_t me;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        chk("halt_front", halt_front, me.hf);
        chk("halt_back", halt_back, me.hb);
        chk("bubble", bubble, me.bub);
        chk("flush", flush, me.fl);
        chk("cpu_halted", cpu_halted, me.ch);
        chk("stall_count", stall_count, me.sc);
        chk("flush_count", flush_count, me.fc);
        if (halt_front) hf_seen++;
        if (flush) fl_seen++;
      end
    end
  end

  initial begin
    #1;
    do_reset();

    hf_seen = 0;
    repeat (SC) drive(1, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0);
    chk("hazard_hold_cycles", hf_seen, SC);
`ifdef PIPE_CTRL_PERF_EN
    chk("hazard_stall_count", stall_count, SC);
`endif

    hf_seen = 0;
    repeat (3) drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("mem_wait_hold_cycles", hf_seen, 3);

    hf_seen = 0;
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0);
    chk("stall_mem_resume_hold_cycles", hf_seen, 5);

    do_reset();
    fl_seen = 0;
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    repeat (2) drive(0, 0, 0, 0, 0);
    chk("branch_flush_cycles", fl_seen, 2);
`ifdef PIPE_CTRL_PERF_EN
    chk("branch_flush_count", flush_count, 1);
`endif

    drive(0, 0, 0, 1, 1);
    repeat (3) drive(0, 0, 0, 0, 0);
    chk("cpu_halted_persist", cpu_halted, 1);
    do_reset();

    for (int i = 0; i < 800; i++) begin
      rd_valid     = ($urandom_range(0, 3) != 0);
      rd_use0      = $urandom_range(0, 1) == 1;
      rd_use1      = $urandom_range(0, 1) == 1;
      rd_src0      = 3'($urandom_range(0, 3));
      rd_src1      = 3'($urandom_range(0, 3));
      ex_wr_en     = $urandom_range(0, 1) == 1;
      ex_dest      = 3'($urandom_range(0, 3));
      mem_req      = ($urandom_range(0, 3) == 0);
      mem_ready    = $urandom_range(0, 1) == 1;
      branch_taken = ($urandom_range(0, 7) == 0);
      halt_instr   = ($urandom_range(0, 59) == 0);
      step();
      if (m_halted && $urandom_range(0, 3) == 0) do_reset();
      else if ($urandom_range(0, 149) == 0) do_reset();
    end

    repeat (2) @(posedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
